// File: rtl/data_unpack.sv
// Reassembles an 8-byte indexed stream into f0_out/fx_out frames with error flags.
// Optional repeated-frame check enabled by defining DATA_UNPACK_REPEAT_CHK_EN.
module data_unpack #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             read_clk,
   input  logic             rst_n,
   input  logic [10:0]      in_num,
   input  logic             ready,
   input  logic             err_clr,
   output logic [31:0]      f0_out,
   output logic [31:0]      fx_out,
   output logic             frame_valid,
   output logic             busy,
   output logic             seq_err,
   output logic             trunc_err,
   output logic             rpt_err,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int unsigned IDX_W   = 3;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned SHADOW_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_HOLD,
      ST_DISCARD
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                ready_q;
   logic [IDX_W-1:0]    exp_idx;
   logic [IDX_W-1:0]    exp_idx_nxt;
   logic [IDX_W-1:0]    cur_idx;
   logic [SHADOW_W-1:0] shadow;
   logic [SHADOW_W-1:0] shadow_nxt;
   logic                frame_done;
   logic                seq_set;
   logic                trunc_set;
   logic                rpt_set;

   logic [IDX_W-1:0]    in_idx;
   logic [BYTE_W-1:0]   in_byte;

   assign in_idx  = in_num[10:8];
   assign in_byte = in_num[7:0];

   // State register
   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-slot decisions; IDLE handles its first slot as index 0 of COLLECT
   always_comb begin
      state_nxt   = state;
      exp_idx_nxt = exp_idx;
      shadow_nxt  = shadow;
      frame_done  = 1'b0;
      seq_set     = 1'b0;
      trunc_set   = 1'b0;
      rpt_set     = 1'b0;
      cur_idx     = (state == ST_IDLE) ? IDX_W'(0) : exp_idx;

      case (state)
         ST_IDLE, ST_COLLECT: begin
            if (ready_q) begin
               if (in_idx == cur_idx) begin
                  shadow_nxt[{cur_idx, 3'b000} +: BYTE_W] = in_byte;
                  if (cur_idx == IDX_W'(7)) begin
                     frame_done  = 1'b1;
                     exp_idx_nxt = IDX_W'(0);
                     state_nxt   = ST_HOLD;
                  end else begin
                     exp_idx_nxt = cur_idx + IDX_W'(1);
                     state_nxt   = ST_COLLECT;
                  end
               end else begin
                  seq_set     = 1'b1;
                  shadow_nxt  = '0;
                  exp_idx_nxt = IDX_W'(0);
                  state_nxt   = ST_DISCARD;
               end
            end else if (state == ST_COLLECT) begin
               trunc_set   = (exp_idx != IDX_W'(0));
               exp_idx_nxt = IDX_W'(0);
               state_nxt   = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (!ready_q) begin
               exp_idx_nxt = IDX_W'(0);
               state_nxt   = ST_IDLE;
            end else begin
`ifdef DATA_UNPACK_REPEAT_CHK_EN
               rpt_set = (in_byte != shadow[{in_idx, 3'b000} +: BYTE_W]);
`endif
            end
         end
         ST_DISCARD: begin
            if (!ready_q) begin
               exp_idx_nxt = IDX_W'(0);
               state_nxt   = ST_IDLE;
            end
         end
         default: begin
            exp_idx_nxt = IDX_W'(0);
            state_nxt   = ST_IDLE;
         end
      endcase
   end

   // Datapath, frame outputs and sticky flags; a set in the clearing cycle wins
   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q     <= 1'b0;
         exp_idx     <= '0;
         shadow      <= '0;
         f0_out      <= '0;
         fx_out      <= '0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
         seq_err     <= 1'b0;
         trunc_err   <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         ready_q     <= ready;
         exp_idx     <= exp_idx_nxt;
         shadow      <= shadow_nxt;
         frame_valid <= frame_done;
         busy        <= (state_nxt == ST_COLLECT);
         seq_err     <= seq_set | (seq_err & ~err_clr);
         trunc_err   <= trunc_set | (trunc_err & ~err_clr);
         if (frame_done) begin
            f0_out <= shadow_nxt[31:0];
            fx_out <= shadow_nxt[63:32];
            if (frame_cnt != {CNT_W{1'b1}}) begin
               frame_cnt <= frame_cnt + CNT_W'(1);
            end
         end
      end
   end

`ifdef DATA_UNPACK_REPEAT_CHK_EN
   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_err <= 1'b0;
      end else begin
         rpt_err <= rpt_set | (rpt_err & ~err_clr);
      end
   end
`else
   assign rpt_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_unpack.sv
// Scoreboard bench for data_unpack: stimulus pushes expected frames, a monitor checks each frame_valid.
module tb_data_unpack;

   // Narrow counter so saturation is reachable in a short run
   localparam int unsigned TB_CNT_W = 4;
   localparam int          CNT_MAX  = 15;

   logic                read_clk = 1'b0;
   logic                rst_n;
   logic [10:0]         in_num;
   logic                ready;
   logic                err_clr;
   logic [31:0]         f0_out;
   logic [31:0]         fx_out;
   logic                frame_valid;
   logic                busy;
   logic                seq_err;
   logic                trunc_err;
   logic                rpt_err;
   logic [TB_CNT_W-1:0] frame_cnt;

   always #5 read_clk = ~read_clk;

   data_unpack #(.CNT_W(TB_CNT_W)) dut (
      .read_clk   (read_clk),
      .rst_n      (rst_n),
      .in_num     (in_num),
      .ready      (ready),
      .err_clr    (err_clr),
      .f0_out     (f0_out),
      .fx_out     (fx_out),
      .frame_valid(frame_valid),
      .busy       (busy),
      .seq_err    (seq_err),
      .trunc_err  (trunc_err),
      .rpt_err    (rpt_err),
      .frame_cnt  (frame_cnt)
   );

   typedef struct packed {
      logic [31:0]         f0;
      logic [31:0]         fx;
      logic [TB_CNT_W-1:0] cnt;
   } exp_t;

   exp_t       sb[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   int         exp_cnt = 0;
   logic [2:0] item_idx[32];
   logic [7:0] item_byte[32];
   logic       exp_rpt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic load_frame(input int base, input logic [31:0] f0, input logic [31:0] fx);
      for (int k = 0; k < 8; k++) begin
         item_idx[base+k]  = 3'(k);
         item_byte[base+k] = (k < 4) ? f0[8*k +: 8] : fx[8*(k-4) +: 8];
      end
   endtask

   task automatic push_frame(input logic [31:0] f0, input logic [31:0] fx);
      if (exp_cnt < CNT_MAX) exp_cnt++;
      sb.push_back({f0, fx, TB_CNT_W'(exp_cnt)});
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, " f0_out"}, 64'(f0_out), 64'h0);
      chk({tag, " fx_out"}, 64'(fx_out), 64'h0);
      chk({tag, " frame_valid"}, 64'(frame_valid), 64'h0);
      chk({tag, " busy"}, 64'(busy), 64'h0);
      chk({tag, " errs"}, 64'({seq_err, trunc_err, rpt_err}), 64'h0);
      chk({tag, " frame_cnt"}, 64'(frame_cnt), 64'h0);
   endtask

   // Slot k of the stream is item k-1; ready drops so that exactly n slots occur
   task automatic run(input int n, input int clr_at, input int rst_at);
      for (int i = 0; i <= n; i++) begin
         @(negedge read_clk);
         ready   = (i < n);
         err_clr = (i == clr_at);
         if (i > 0) in_num = {item_idx[i-1], item_byte[i-1]};
         if (i == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk_zero_outputs("midreset");
            ready   = 1'b0;
            err_clr = 1'b0;
            @(negedge read_clk);
            rst_n = 1'b1;
            return;
         end
         @(posedge read_clk);
      end
      @(negedge read_clk);
      ready   = 1'b0;
      err_clr = 1'b0;
      in_num  = '0;
      repeat (2) @(posedge read_clk);
      @(negedge read_clk);
   endtask

   task automatic clear_errs();
      @(negedge read_clk);
      err_clr = 1'b1;
      @(negedge read_clk);
      err_clr = 1'b0;
      chk("cleared errs", 64'({seq_err, trunc_err, rpt_err}), 64'h0);
   endtask

   // Monitor: every frame_valid cycle must match the next queued frame
   always @(negedge read_clk) begin
      if (rst_n && frame_valid) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected frame_valid: got f0 %0h fx %0h cnt %0d expected none",
                     f0_out, fx_out, frame_cnt);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("frame f0_out", 64'(f0_out), 64'(e.f0));
            chk("frame fx_out", 64'(fx_out), 64'(e.fx));
            chk("frame frame_cnt", 64'(frame_cnt), 64'(e.cnt));
         end
      end
   end

   initial begin
`ifdef DATA_UNPACK_REPEAT_CHK_EN
      exp_rpt = 1'b1;
`else
      exp_rpt = 1'b0;
`endif
      rst_n   = 1'b0;
      ready   = 1'b0;
      err_clr = 1'b0;
      in_num  = '0;
      repeat (3) @(posedge read_clk);
      @(negedge read_clk);
      chk_zero_outputs("reset");
      rst_n = 1'b1;

      // Basic frame
      load_frame(0, 32'h12345678, 32'hABCDEF09);
      push_frame(32'h12345678, 32'hABCDEF09);
      run(8, -1, -1);
      chk("frameA consumed", 64'(sb.size()), 64'h0);
      chk("frameA no errs", 64'({seq_err, trunc_err, rpt_err}), 64'h0);

      // Out-of-order index; a following clean 0..7 must be ignored in DISCARD
      item_idx[0] = 3'd0; item_byte[0] = 8'h11;
      item_idx[1] = 3'd1; item_byte[1] = 8'h22;
      item_idx[2] = 3'd3; item_byte[2] = 8'h33;
      load_frame(3, 32'hDEADBEEF, 32'h55AA55AA);
      run(11, -1, -1);
      chk("seq seq_err", 64'(seq_err), 64'h1);
      chk("seq trunc_err", 64'(trunc_err), 64'h0);
      chk("seq f0 kept", 64'(f0_out), 64'h12345678);
      clear_errs();

      // Truncated frame, then a full one
      load_frame(0, 32'hCAFEF00D, 32'h01020304);
      run(5, -1, -1);
      chk("trunc trunc_err", 64'(trunc_err), 64'h1);
      chk("trunc f0 kept", 64'(f0_out), 64'h12345678);
      chk("trunc fx kept", 64'(fx_out), 64'hABCDEF09);
      push_frame(32'hCAFEF00D, 32'h01020304);
      run(8, -1, -1);
      chk("after trunc frame_cnt", 64'(frame_cnt), 64'h2);
      clear_errs();

      // Repeated pass with byte 5 altered
      load_frame(0, 32'h0F1E2D3C, 32'h4B5A6978);
      load_frame(8, 32'h0F1E2D3C, 32'h4B5A6978);
      item_byte[13] = item_byte[13] ^ 8'h5A;
      push_frame(32'h0F1E2D3C, 32'h4B5A6978);
      run(16, -1, -1);
      chk("repeat rpt_err", 64'(rpt_err), 64'(exp_rpt));
      chk("repeat frame_cnt", 64'(frame_cnt), 64'h3);
      chk("repeat fx kept", 64'(fx_out), 64'h4B5A6978);
      clear_errs();

      // err_clr coincident with the seq_err set
      item_idx[0] = 3'd0; item_byte[0] = 8'h01;
      item_idx[1] = 3'd1; item_byte[1] = 8'h02;
      item_idx[2] = 3'd3; item_byte[2] = 8'h03;
      run(3, 3, -1);
      chk("clr coincident seq_err", 64'(seq_err), 64'h1);
      clear_errs();

      // Drive the counter into saturation
      for (int k = 0; k < 13; k++) begin
         load_frame(0, 32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k * 3));
         push_frame(32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k * 3));
         run(8, -1, -1);
      end
      chk("saturated frame_cnt", 64'(frame_cnt), 64'(CNT_MAX));

      // Reset after idx3, then a full frame restarts counting
      load_frame(0, 32'h77665544, 32'h33221100);
      run(8, -1, 5);
      exp_cnt = 0;
      repeat (2) @(negedge read_clk);
      chk("post-reset frame_cnt", 64'(frame_cnt), 64'h0);
      load_frame(0, 32'h89ABCDEF, 32'h76543210);
      push_frame(32'h89ABCDEF, 32'h76543210);
      run(8, -1, -1);
      chk("post-reset frame_cnt 1", 64'(frame_cnt), 64'h1);
      chk("scoreboard drained", 64'(sb.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
